edit_mode_ctrl: RTL and testbench
=================================

// Module: edit_mode_ctrl
// PURPOSE
//  UI sequencer for the clock/date/chronometer display. Selects the display page
//  (d_pg) and the cursor position for each edit page (p_ho/p_fe/p_cr).
//  Holds a BCD shadow copy of the field being edited and applies up/down with range wrap.
//  Commits the edited value to the RTC/chrono datapath with a one-cycle write strobe.
// PARAMETERS
//  TIMEOUT_S  10  seconds of button inactivity before abandoning edit; 0 = never
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  tick_1hz   in   1   one-cycle pulse per second (timeout timebase)
//  btn_mode   in   1   one-cycle pulse (debounced upstream): next page / commit
//  btn_next   in   1   one-cycle pulse: advance cursor
//  btn_up     in   1   one-cycle pulse: increment field at cursor
//  btn_down   in   1   one-cycle pulse: decrement field at cursor
//  formato    in   1   0 = 24 h, 1 = 12 h (hour range on page 1)
//  hora_in    in   24  live {HH,MM,SS} BCD
//  fecha_in   in   24  live {DD,MM,YY} BCD
//  crono_in   in   24  live chrono preset {HH,MM,SS} BCD
//  d_pg       out  2   0 = normal, 1 = edit hora, 2 = edit fecha, 3 = edit crono
//  p_ho       out  3   hora cursor: 0 none, 1/2/3 = field [23:16]/[15:8]/[7:0]
//  p_fe       out  3   fecha cursor, same encoding
//  p_cr       out  3   crono cursor, same encoding
//  edit_data  out  24  shadow value of the current edit page
//  wr_hora    out  1   one-cycle commit strobe, hora
//  wr_fecha   out  1   one-cycle commit strobe, fecha
//  wr_crono   out  1   one-cycle commit strobe, crono
//  wr_data    out  24  committed value; valid while any wr_* = 1
// BEHAVIOUR
//  Reset
//   - All outputs are 0. Timeout counter is 0.
//   - Reset mid-edit drops the shadow and produces no write strobe.
//  Timing
//   - All outputs are registered. A button pulse in cycle n takes effect in cycle n+1.
//   - wr_* fall back to 0 in the following cycle.
//  Button priority (one action per cycle)
//   - btn_mode > btn_next > btn_up > btn_down. Lower-priority pulses in the same cycle are dropped.
//  Page FSM: NORMAL(0) -> HORA(1) -> FECHA(2) -> CRONO(3) -> NORMAL, advanced on btn_mode
//   - Entering page k: edit_data <= that page's *_in; that page's cursor <= 1; all other cursors <= 0.
//   - Leaving page k (1..3) via btn_mode:
//     - the page's wr_* = 1 for exactly one cycle;
//     - wr_data = edit_data as it stood before the press;
//     - in that same cycle, d_pg/edit_data already show the next page.
//   - Entering NORMAL: all cursors 0; edit_data holds its last value.
//  Cursor
//   - btn_next steps 1 -> 2 -> 3 -> 1.
//   - In NORMAL, btn_next/up/down are ignored.
//  Up/down, mod-range on the 8-bit BCD field at the cursor (max -> min on up, min -> max on down)
//   - HORA:  hours 00-23 (formato = 0) or 01-12 (formato = 1); minutes 00-59; seconds 00-59.
//   - FECHA: day 01-31 (no month-length check); month 01-12; year 00-99.
//   - CRONO: 00-23, 00-59, 00-59.
//   - A field that is out of range or has a non-BCD nibble goes to min on either up or down.
//   - Result is always valid packed BCD; no binary intermediate is exposed.
//  Timeout
//   - The counter clears on any accepted button pulse and on any page change.
//   - It increments on tick_1hz while d_pg != 0.
//   - When it reaches TIMEOUT_S: d_pg <= 0, cursors <= 0, no wr_* strobe (edit discarded).
//   - A button pulse in the same cycle as the expiring tick wins; the counter restarts.
//  formato changing mid-edit does not alter the shadow; the next up/down applies the new range.
// TESTING
//  1 Reset held 2 cycles while in FECHA -> d_pg=0, p_*=0, wr_*=0 throughout, edit_data=0.
//  2 hora_in=24'h235958, formato=0; mode; up -> d_pg=1, p_ho=1, then edit_data=24'h005958.
//  3 formato=1, hour field 8'h12: up -> 8'h01; down -> 8'h12; hour 8'h45: up -> 8'h01.
//  4 FECHA fecha_in=24'h011299:
//    - next, up -> 24'h010199; next, up -> 24'h010100;
//    - mode -> wr_fecha=1 for 1 cycle, wr_data=24'h010100, d_pg=3, p_cr=1, p_fe=0.
//  5 TIMEOUT_S=3, in HORA with edits, three tick_1hz and no buttons -> d_pg=0, no wr_hora.
//  6 btn_mode+btn_up+btn_down in the same cycle in CRONO -> wr_crono pulse, d_pg=0, shadow unchanged by up/down.

Source files
------------

// File: rtl/edit_mode_ctrl.sv
// edit_mode_ctrl: page/cursor sequencer for the clock, date and chrono display.
// Keeps a packed-BCD shadow of the page being edited, applies up/down with
// range wrap on the field under the cursor, and commits the shadow to the
// datapath with a one-cycle write strobe when the user leaves the page.
module edit_mode_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        formato,
  input  logic [23:0] hora_in,
  input  logic [23:0] fecha_in,
  input  logic [23:0] crono_in,
  output logic [1:0]  d_pg,
  output logic [2:0]  p_ho,
  output logic [2:0]  p_fe,
  output logic [2:0]  p_cr,
  output logic [23:0] edit_data,
  output logic        wr_hora,
  output logic        wr_fecha,
  output logic        wr_crono,
  output logic [23:0] wr_data
);

  localparam int CW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    PG_NORMAL = 2'd0,
    PG_HORA   = 2'd1,
    PG_FECHA  = 2'd2,
    PG_CRONO  = 2'd3
  } page_t;

  // Registered state (every output comes straight from one of these).
  page_t       r_pg;
  logic [2:0]  r_p_ho, r_p_fe, r_p_cr;
  logic [23:0] r_edit;
  logic        r_wr_hora, r_wr_fecha, r_wr_crono;
  logic [23:0] r_wr_data;
  logic [CW-1:0] r_cnt;

  // Next-state values.
  page_t       w_pg_next;
  logic [2:0]  w_p_ho_next, w_p_fe_next, w_p_cr_next;
  logic [23:0] w_edit_next;
  logic        w_wr_hora_next, w_wr_fecha_next, w_wr_crono_next;
  logic [23:0] w_wr_data_next;
  logic [CW-1:0] w_cnt_next;

  // Field datapath.
  logic [2:0]  w_cur;
  logic [7:0]  w_fld [0:2];
  logic [7:0]  w_fld_cur;
  logic [7:0]  w_fld_new;
  logic [7:0]  w_lo, w_hi;
  logic [23:0] w_edit_upd;
  logic        w_expire;

  // One up/down step on a packed-BCD byte; anything out of range or
  // non-decimal snaps to the minimum so the shadow is always valid BCD.
  function automatic logic [7:0] bcd_step(input logic [7:0] f, input logic [7:0] lo,
                                          input logic [7:0] hi, input logic up);
    logic       ok;
    logic [7:0] r;
    ok = (f[7:4] <= 4'd9) && (f[3:0] <= 4'd9) && (f >= lo) && (f <= hi);
    if (!ok) begin
      r = lo;
    end else if (up) begin
      if (f == hi)               r = lo;
      else if (f[3:0] == 4'd9)   r = {f[7:4] + 4'd1, 4'd0};
      else                       r = {f[7:4], f[3:0] + 4'd1};
    end else begin
      if (f == lo)               r = hi;
      else if (f[3:0] == 4'd0)   r = {f[7:4] - 4'd1, 4'd9};
      else                       r = {f[7:4], f[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Split the shadow into its three bytes and rebuild it with the edited byte
  // replacing the one under the cursor (cursor 1 = most significant byte).
  for (genvar gi = 0; gi < 3; gi++) begin : g_fld
    assign w_fld[gi] = r_edit[8*(2-gi) +: 8];
    assign w_edit_upd[8*(2-gi) +: 8] = (w_cur == 3'(gi + 1)) ? w_fld_new : w_fld[gi];
  end

  // Cursor of the active page, the byte it selects, and that field's range.
  always_comb begin
    w_cur     = 3'd0;
    w_fld_cur = w_fld[2];
    w_lo      = 8'h00;
    w_hi      = 8'h59;
    case (r_pg)
      PG_HORA:  w_cur = r_p_ho;
      PG_FECHA: w_cur = r_p_fe;
      PG_CRONO: w_cur = r_p_cr;
      default:  w_cur = 3'd0;
    endcase
    case (w_cur)
      3'd1:    w_fld_cur = w_fld[0];
      3'd2:    w_fld_cur = w_fld[1];
      default: w_fld_cur = w_fld[2];
    endcase
    case (r_pg)
      PG_HORA: begin
        if (w_cur == 3'd1) begin
          w_lo = formato ? 8'h01 : 8'h00;
          w_hi = formato ? 8'h12 : 8'h23;
        end
      end
      PG_FECHA: begin
        case (w_cur)
          3'd1:    begin w_lo = 8'h01; w_hi = 8'h31; end
          3'd2:    begin w_lo = 8'h01; w_hi = 8'h12; end
          default: begin w_lo = 8'h00; w_hi = 8'h99; end
        endcase
      end
      PG_CRONO: begin
        if (w_cur == 3'd1) w_hi = 8'h23;
      end
      default: ;
    endcase
  end

  assign w_fld_new = bcd_step(w_fld_cur, w_lo, w_hi, btn_up);
  assign w_expire  = (TIMEOUT_S != 0) && ((int'(r_cnt) + 1) == TIMEOUT_S);

  // Page FSM, cursors, shadow, commit strobes and inactivity timer.
  always_comb begin
    w_pg_next       = r_pg;
    w_p_ho_next     = r_p_ho;
    w_p_fe_next     = r_p_fe;
    w_p_cr_next     = r_p_cr;
    w_edit_next     = r_edit;
    w_wr_hora_next  = 1'b0;
    w_wr_fecha_next = 1'b0;
    w_wr_crono_next = 1'b0;
    w_wr_data_next  = r_wr_data;
    w_cnt_next      = r_cnt;

    if (btn_mode) begin
      w_cnt_next  = '0;
      w_p_ho_next = 3'd0;
      w_p_fe_next = 3'd0;
      w_p_cr_next = 3'd0;
      case (r_pg)
        PG_NORMAL: begin
          w_pg_next   = PG_HORA;
          w_edit_next = hora_in;
          w_p_ho_next = 3'd1;
        end
        PG_HORA: begin
          w_pg_next      = PG_FECHA;
          w_wr_hora_next = 1'b1;
          w_wr_data_next = r_edit;
          w_edit_next    = fecha_in;
          w_p_fe_next    = 3'd1;
        end
        PG_FECHA: begin
          w_pg_next       = PG_CRONO;
          w_wr_fecha_next = 1'b1;
          w_wr_data_next  = r_edit;
          w_edit_next     = crono_in;
          w_p_cr_next     = 3'd1;
        end
        default: begin
          w_pg_next       = PG_NORMAL;
          w_wr_crono_next = 1'b1;
          w_wr_data_next  = r_edit;
        end
      endcase
    end else if (r_pg != PG_NORMAL && btn_next) begin
      w_cnt_next = '0;
      case (r_pg)
        PG_HORA:  w_p_ho_next = (r_p_ho == 3'd3) ? 3'd1 : r_p_ho + 3'd1;
        PG_FECHA: w_p_fe_next = (r_p_fe == 3'd3) ? 3'd1 : r_p_fe + 3'd1;
        default:  w_p_cr_next = (r_p_cr == 3'd3) ? 3'd1 : r_p_cr + 3'd1;
      endcase
    end else if (r_pg != PG_NORMAL && (btn_up || btn_down)) begin
      w_cnt_next  = '0;
      w_edit_next = w_edit_upd;
    end else if (r_pg != PG_NORMAL && tick_1hz && TIMEOUT_S != 0) begin
      if (w_expire) begin
        // Abandon the edit: back to the normal page, nothing committed.
        w_pg_next   = PG_NORMAL;
        w_p_ho_next = 3'd0;
        w_p_fe_next = 3'd0;
        w_p_cr_next = 3'd0;
        w_cnt_next  = '0;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pg       <= PG_NORMAL;
      r_p_ho     <= 3'd0;
      r_p_fe     <= 3'd0;
      r_p_cr     <= 3'd0;
      r_edit     <= 24'h0;
      r_wr_hora  <= 1'b0;
      r_wr_fecha <= 1'b0;
      r_wr_crono <= 1'b0;
      r_wr_data  <= 24'h0;
      r_cnt      <= '0;
    end else begin
      r_pg       <= w_pg_next;
      r_p_ho     <= w_p_ho_next;
      r_p_fe     <= w_p_fe_next;
      r_p_cr     <= w_p_cr_next;
      r_edit     <= w_edit_next;
      r_wr_hora  <= w_wr_hora_next;
      r_wr_fecha <= w_wr_fecha_next;
      r_wr_crono <= w_wr_crono_next;
      r_wr_data  <= w_wr_data_next;
      r_cnt      <= w_cnt_next;
    end
  end

  assign d_pg      = r_pg;
  assign p_ho      = r_p_ho;
  assign p_fe      = r_p_fe;
  assign p_cr      = r_p_cr;
  assign edit_data = r_edit;
  assign wr_hora   = r_wr_hora;
  assign wr_fecha  = r_wr_fecha;
  assign wr_crono  = r_wr_crono;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_edit_mode_ctrl.sv
// tb_edit_mode_ctrl: directed scenarios plus randomized traffic for
// edit_mode_ctrl, checked against a decimal-arithmetic model of the UI rules.
module tb_edit_mode_ctrl;

  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic        formato = 1'b0;
  logic [23:0] hora_in = 24'h0, fecha_in = 24'h0, crono_in = 24'h0;
  logic [1:0]  d_pg;
  logic [2:0]  p_ho, p_fe, p_cr;
  logic [23:0] edit_data;
  logic        wr_hora, wr_fecha, wr_crono;
  logic [23:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: page number, cursor of the active page, shadow, strobe kind.
  int          m_pg = 0, m_cur = 0, m_cnt = 0, m_wr = 0;
  logic [23:0] m_edit = 24'h0, m_wr_data = 24'h0;

  edit_mode_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .formato(formato), .hora_in(hora_in), .fecha_in(fecha_in), .crono_in(crono_in),
    .d_pg(d_pg), .p_ho(p_ho), .p_fe(p_fe), .p_cr(p_cr), .edit_data(edit_data),
    .wr_hora(wr_hora), .wr_fecha(wr_fecha), .wr_crono(wr_crono), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic int rlo(input int pg, input int cur, input bit fmt);
    if (pg == 1 && cur == 1) return fmt ? 1 : 0;
    if (pg == 2 && cur < 3)  return 1;
    return 0;
  endfunction

  function automatic int rhi(input int pg, input int cur, input bit fmt);
    if (pg == 1 && cur == 1) return fmt ? 12 : 23;
    if (pg == 2) return (cur == 1) ? 31 : (cur == 2) ? 12 : 99;
    if (pg == 3 && cur == 1) return 23;
    return 59;
  endfunction

  // Decimal view of a field: decode, step with wrap, re-encode.
  function automatic logic [7:0] m_adj(input logic [7:0] f, input int lo, input int hi, input bit up);
    int h, l, v;
    h = int'(f[7:4]);
    l = int'(f[3:0]);
    v = h * 10 + l;
    if (h > 9 || l > 9 || v < lo || v > hi) v = lo;
    else if (up) v = (v == hi) ? lo : v + 1;
    else         v = (v == lo) ? hi : v - 1;
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [61:0] exp_vec();
    logic [2:0] eh, ef, ec;
    eh = (m_pg == 1) ? 3'(m_cur) : 3'd0;
    ef = (m_pg == 2) ? 3'(m_cur) : 3'd0;
    ec = (m_pg == 3) ? 3'(m_cur) : 3'd0;
    return {2'(m_pg), eh, ef, ec, m_edit, m_wr == 1, m_wr == 2, m_wr == 3,
            (m_wr != 0) ? m_wr_data : 24'h0};
  endfunction

  function automatic logic [61:0] obs_vec();
    return {d_pg, p_ho, p_fe, p_cr, edit_data, wr_hora, wr_fecha, wr_crono,
            (wr_hora | wr_fecha | wr_crono) ? wr_data : 24'h0};
  endfunction

  // Drive one clock of inputs and advance the model by the same rules.
  task automatic cycle(input bit rst, input bit md, input bit nx, input bit u,
                       input bit d, input bit tk);
    int          sh;
    logic [7:0]  f;
    logic [23:0] mask;
    reset = rst; btn_mode = md; btn_next = nx; btn_up = u; btn_down = d; tick_1hz = tk;
    if (rst) begin
      m_pg = 0; m_cur = 0; m_cnt = 0; m_wr = 0; m_edit = 24'h0; m_wr_data = 24'h0;
    end else begin
      m_wr = 0;
      if (md) begin
        if (m_pg != 0) begin m_wr = m_pg; m_wr_data = m_edit; end
        m_pg  = (m_pg + 1) % 4;
        m_cur = (m_pg != 0) ? 1 : 0;
        m_cnt = 0;
        if (m_pg == 1) m_edit = hora_in;
        if (m_pg == 2) m_edit = fecha_in;
        if (m_pg == 3) m_edit = crono_in;
      end else if (m_pg != 0 && (nx || u || d)) begin
        m_cnt = 0;
        if (nx) m_cur = m_cur % 3 + 1;
        else begin
          sh   = (3 - m_cur) * 8;
          f    = 8'(m_edit >> sh);
          mask = 24'hFF;
          m_edit = (m_edit & ~(mask << sh)) |
                   (24'(m_adj(f, rlo(m_pg, m_cur, formato), rhi(m_pg, m_cur, formato), u)) << sh);
        end
      end else if (m_pg != 0 && tk && TO > 0) begin
        m_cnt++;
        if (m_cnt == TO) begin m_pg = 0; m_cur = 0; m_cnt = 0; end
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_vec() !== 62'h0) begin
      n_bad++; $display("FAIL reset_init: got %h want 0", obs_vec());
    end
    $display("[reset] initial outputs %h", obs_vec());
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (d_pg !== 2'd2) begin n_bad++; $display("FAIL reset_pre_fecha: d_pg=%0d want 2", d_pg); end
    for (int i = 0; i < 3; i++) begin
      cycle(i < 2, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_vec() !== 62'h0) begin
        n_bad++; $display("FAIL reset_hold%0d: got %h want 0", i, obs_vec());
      end
      $display("[reset] cycle %0d reset=%0d outputs %h", i, (i < 2), obs_vec());
    end
  endtask

  task automatic test_hour_wrap();
    cycle(1, 0, 0, 0, 0, 0);
    hora_in = 24'h235958; formato = 1'b0;
    cycle(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (d_pg !== 2'd1 || p_ho !== 3'd1 || edit_data !== 24'h235958) begin
      n_bad++; $display("FAIL hora_enter: d_pg=%0d p_ho=%0d edit=%h want 1 1 235958", d_pg, p_ho, edit_data);
    end
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (edit_data !== 24'h005958) begin n_bad++; $display("FAIL hora_up_wrap: edit=%h want 005958", edit_data); end
    $display("[hour_wrap] up -> %h", edit_data);
    cycle(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (edit_data !== 24'h235958) begin n_bad++; $display("FAIL hora_down_wrap: edit=%h want 235958", edit_data); end
    $display("[hour_wrap] down -> %h", edit_data);
  endtask

  task automatic test_formato12();
    cycle(1, 0, 0, 0, 0, 0);
    formato = 1'b1; hora_in = 24'h120000;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (edit_data !== 24'h010000) begin n_bad++; $display("FAIL f12_up: edit=%h want 010000", edit_data); end
    cycle(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (edit_data !== 24'h120000) begin n_bad++; $display("FAIL f12_down: edit=%h want 120000", edit_data); end
    $display("[formato12] 12 up/down -> %h", edit_data);
    cycle(1, 0, 0, 0, 0, 0);
    hora_in = 24'h450000;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (edit_data !== 24'h010000) begin n_bad++; $display("FAIL f12_bad_up: edit=%h want 010000", edit_data); end
    cycle(1, 0, 0, 0, 0, 0);
    hora_in = 24'h4A0000;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (edit_data !== 24'h010000) begin n_bad++; $display("FAIL f12_nonbcd_down: edit=%h want 010000", edit_data); end
    $display("[formato12] invalid hour -> %h", edit_data);
    formato = 1'b0;
  endtask

  task automatic test_fecha();
    cycle(1, 0, 0, 0, 0, 0);
    fecha_in = 24'h011299; crono_in = 24'h010203;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (d_pg !== 2'd2 || p_fe !== 3'd1 || p_ho !== 3'd0 || edit_data !== 24'h011299) begin
      n_bad++; $display("FAIL fecha_enter: d_pg=%0d p_fe=%0d p_ho=%0d edit=%h", d_pg, p_fe, p_ho, edit_data);
    end
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (edit_data !== 24'h010199) begin n_bad++; $display("FAIL fecha_month: edit=%h want 010199", edit_data); end
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (edit_data !== 24'h010100) begin n_bad++; $display("FAIL fecha_year: edit=%h want 010100", edit_data); end
    cycle(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (p_fe !== 3'd1) begin n_bad++; $display("FAIL fecha_cursor_wrap: p_fe=%0d want 1", p_fe); end
    cycle(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (wr_fecha !== 1'b1 || wr_data !== 24'h010100 || d_pg !== 2'd3 || p_cr !== 3'd1 ||
        p_fe !== 3'd0 || edit_data !== 24'h010203 || wr_hora !== 1'b0 || wr_crono !== 1'b0) begin
      n_bad++; $display("FAIL fecha_commit: wr_fecha=%0d wr_data=%h d_pg=%0d p_cr=%0d p_fe=%0d edit=%h",
                        wr_fecha, wr_data, d_pg, p_cr, p_fe, edit_data);
    end
    $display("[fecha] commit wr_data=%h", wr_data);
    cycle(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (wr_fecha !== 1'b0) begin n_bad++; $display("FAIL fecha_strobe_width: wr_fecha=%0d want 0", wr_fecha); end
  endtask

  task automatic test_timeout();
    cycle(1, 0, 0, 0, 0, 0);
    hora_in = 24'h101010;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (d_pg !== ((i < 3) ? 2'd1 : 2'd0) || wr_hora !== 1'b0 || p_ho !== ((i < 3) ? 3'd1 : 3'd0)) begin
        n_bad++; $display("FAIL timeout_tick%0d: d_pg=%0d p_ho=%0d wr_hora=%0d", i, d_pg, p_ho, wr_hora);
      end
      $display("[timeout] tick %0d d_pg=%0d", i, d_pg);
    end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    n_cmp++;
    if (d_pg !== 2'd1) begin n_bad++; $display("FAIL timeout_button_wins: d_pg=%0d want 1", d_pg); end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (d_pg !== 2'd1) begin n_bad++; $display("FAIL timeout_restart: d_pg=%0d want 1", d_pg); end
    cycle(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (d_pg !== 2'd0 || wr_hora !== 1'b0) begin
      n_bad++; $display("FAIL timeout_second: d_pg=%0d wr_hora=%0d want 0 0", d_pg, wr_hora);
    end
  endtask

  task automatic test_priority();
    cycle(1, 0, 0, 0, 0, 0);
    crono_in = 24'h123456;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 0);
    n_cmp++;
    if (wr_crono !== 1'b1 || wr_data !== 24'h123456 || d_pg !== 2'd0 || edit_data !== 24'h123456 || p_cr !== 3'd0) begin
      n_bad++; $display("FAIL prio_mode: wr_crono=%0d wr_data=%h d_pg=%0d edit=%h p_cr=%0d",
                        wr_crono, wr_data, d_pg, edit_data, p_cr);
    end
    $display("[priority] crono commit %h", wr_data);
    hora_in = 24'h123456;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    n_cmp++;
    if (p_ho !== 3'd2 || edit_data !== 24'h123456) begin
      n_bad++; $display("FAIL prio_next: p_ho=%0d edit=%h want 2 123456", p_ho, edit_data);
    end
    cycle(0, 0, 0, 1, 1, 0);
    n_cmp++;
    if (edit_data !== 24'h123556) begin n_bad++; $display("FAIL prio_up: edit=%h want 123556", edit_data); end
  endtask

  function automatic logic [7:0] rand_field();
    if ($urandom_range(0, 4) == 0) return 8'($urandom());
    return m_adj(8'h00, 0, 99, 1'b0) == 8'h99 ? 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9)) : 8'h00;
  endfunction

  task automatic test_random();
    int rate;
    bit r, md, nx, u, d, tk;
    cycle(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 40; b++) begin
      rate = $urandom_range(0, 1) ? 45 : 6;
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, 7) == 0)
          hora_in = {rand_field(), rand_field(), rand_field()};
        if ($urandom_range(0, 7) == 0)
          fecha_in = {rand_field(), rand_field(), rand_field()};
        if ($urandom_range(0, 7) == 0)
          crono_in = {rand_field(), rand_field(), rand_field()};
        if ($urandom_range(0, 29) == 0) formato = ~formato;
        r  = ($urandom_range(0, 299) == 0);
        md = 0; nx = 0; u = 0; d = 0;
        if ($urandom_range(0, 99) < rate) begin
          md = ($urandom_range(0, 4) == 0);
          nx = ($urandom_range(0, 2) == 0);
          u  = ($urandom_range(0, 1) == 0);
          d  = ($urandom_range(0, 1) == 0);
        end
        tk = ($urandom_range(0, 2) == 0);
        cycle(r, md, nx, u, d, tk);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL random_b%0d_c%0d: got %h want %h", b, c, obs_vec(), exp_vec());
        end
        if (m_wr != 0) $display("[random] commit page %0d data %h", m_wr, m_wr_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hour_wrap();
    test_formato12();
    test_fecha();
    test_timeout();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
